// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared types and helpers for the noise gate
package gate_pkg;

  typedef shortint sample_t;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  function automatic int gate_unity(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/noise_gate_env.sv
// rtl/noise_gate_env.sv - peak envelope follower with shift-based decay
module noise_gate_env
  import gate_pkg::*;
#(
  parameter int DECAY_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  sample_t     sample,
  output logic [15:0] env_next,
  output logic [15:0] env
);

  logic [15:0] mag;
  logic [15:0] decayed;

  // -32768 has no positive twin in 16 bits, so it clamps to full scale
  always_comb begin
    if (sample == 16'sh8000)
      mag = 16'h7fff;
    else if (sample < 0)
      mag = 16'(-sample);
    else
      mag = 16'(sample);
  end

  always_comb begin
    decayed  = env - (env >> DECAY_SHIFT);
    env_next = (mag > decayed) ? mag : decayed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      env <= '0;
    else if (in_valid)
      env <= env_next;
  end

endmodule

// File: rtl/noise_gate.sv
// rtl/noise_gate.sv - hysteretic noise gate with ramped gain ahead of overdrive
module noise_gate
  import gate_pkg::*;
#(
  parameter int GATE_FRAC    = 8,
  parameter int DECAY_SHIFT  = 6,
  parameter int HOLD_SAMPLES = 480,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] signal_in,
  input  logic        [15:0] thresh_open,
  input  logic        [15:0] thresh_close,
  output logic               out_valid,
  output logic signed [15:0] signal_out,
  output logic               gate_open
);

  localparam int GW = GATE_FRAC + 1;
  localparam int HW = $clog2(HOLD_SAMPLES);
  localparam int PW = 17 + GATE_FRAC;

  localparam logic [GW-1:0] UNITY  = GW'(gate_unity(GATE_FRAC));
  localparam logic [GW-1:0] A_STEP = GW'(ATTACK_STEP);
  localparam logic [GW-1:0] R_STEP = GW'(RELEASE_STEP);

  localparam logic [2:0] ST_CLOSED  = CLOSED;
  localparam logic [2:0] ST_ATTACK  = ATTACK;
  localparam logic [2:0] ST_OPEN    = OPEN;
  localparam logic [2:0] ST_HOLD    = HOLD;
  localparam logic [2:0] ST_RELEASE = RELEASE;

  logic [2:0]           state, state_nx;
  logic [GW-1:0]        gain, gain_nx;
  logic [HW-1:0]        hold_cnt, hold_nx;
  logic [15:0]          env_next;
  logic [15:0]          env_level_unused;
  logic                 open_hit, close_low;
  logic                 go_attack, go_release;
  logic signed [PW-1:0] s_ext, g_ext, prod;

  noise_gate_env #(
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_env (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .sample   (signal_in),
    .env_next (env_next),
    .env      (env_level_unused)
  );

  assign open_hit  = (env_next >= thresh_open);
  assign close_low = (env_next < thresh_close);

  always_comb begin
    state_nx   = state;
    gain_nx    = gain;
    hold_nx    = hold_cnt;
    go_attack  = 1'b0;
    go_release = 1'b0;
    case (state)
      ST_CLOSED:  go_attack = open_hit;
      ST_ATTACK:  go_attack = 1'b1;
      ST_OPEN: begin
        if (close_low) begin
          state_nx = ST_HOLD;
          hold_nx  = HW'(HOLD_SAMPLES - 1);
        end
      end
      ST_HOLD: begin
        if (open_hit)
          state_nx = ST_OPEN;
        else if (hold_cnt == '0)
          go_release = 1'b1;
        else
          hold_nx = hold_cnt - HW'(1);
      end
      ST_RELEASE: begin
        go_attack  = open_hit;
        go_release = !open_hit;
      end
      default: state_nx = ST_CLOSED;
    endcase

    // Ramps take their first step in the very sample that enters them
    if (go_attack) begin
      if (gain >= UNITY - A_STEP) begin
        gain_nx  = UNITY;
        state_nx = ST_OPEN;
      end else begin
        gain_nx  = gain + A_STEP;
        state_nx = ST_ATTACK;
      end
    end else if (go_release) begin
      if (gain <= R_STEP) begin
        gain_nx  = '0;
        state_nx = ST_CLOSED;
      end else begin
        gain_nx  = gain - R_STEP;
        state_nx = ST_RELEASE;
      end
    end
  end

  always_comb begin
    s_ext = PW'(signal_in);
    g_ext = PW'({1'b0, gain_nx});
    prod  = s_ext * g_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLOSED;
      gain       <= '0;
      hold_cnt   <= '0;
      signal_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state      <= state_nx;
        gain       <= gain_nx;
        hold_cnt   <= hold_nx;
        signal_out <= 16'(prod >>> GATE_FRAC);
      end
    end
  end

  assign gate_open = (state != ST_CLOSED);

endmodule

// File: tb/tb_noise_gate.sv
// tb/tb_noise_gate.sv - randomized self-checking bench for noise_gate
module tb_noise_gate;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] signal_in;
  logic        [15:0] thresh_open;
  logic        [15:0] thresh_close;
  logic               out_valid;
  logic signed [15:0] signal_out;
  logic               gate_open;

  noise_gate dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .signal_in    (signal_in),
    .thresh_open  (thresh_open),
    .thresh_close (thresh_close),
    .out_valid    (out_valid),
    .signal_out   (signal_out),
    .gate_open    (gate_open)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  // Reference model: gain as an integer 0..256, mode as a plain number
  localparam int M_CLOSED = 0, M_ATTACK = 1, M_OPEN = 2, M_HOLD = 3, M_RELEASE = 4;
  int m_env, m_gain, m_hold, m_mode, exp_out;

  function automatic void model_reset();
    m_env = 0; m_gain = 0; m_hold = 0; m_mode = M_CLOSED; exp_out = 0;
  endfunction

  function automatic void ramp_up();
    m_gain = (m_gain + 16 > 256) ? 256 : m_gain + 16;
    m_mode = (m_gain == 256) ? M_OPEN : M_ATTACK;
  endfunction

  function automatic void ramp_down();
    m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
    m_mode = (m_gain == 0) ? M_CLOSED : M_RELEASE;
  endfunction

  function automatic int model_sample(input int x);
    int a, kept;
    bit loud, quiet;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    kept  = m_env - m_env / 64;
    m_env = (a > kept) ? a : kept;
    loud  = (m_env >= int'(thresh_open));
    quiet = (m_env < int'(thresh_close));
    case (m_mode)
      M_CLOSED:  if (loud) ramp_up();
      M_ATTACK:  ramp_up();
      M_OPEN:    if (quiet) begin m_mode = M_HOLD; m_hold = 479; end
      M_HOLD: begin
        if (loud) m_mode = M_OPEN;
        else if (m_hold == 0) ramp_down();
        else m_hold--;
      end
      default:   if (loud) ramp_up(); else ramp_down();
    endcase
    return (x * m_gain) >>> 8;
  endfunction

  task automatic cyc(input bit v, input int x);
    in_valid  = v;
    signal_in = 16'(x);
    if (v) exp_out = model_sample(x);
    @(negedge clk);
    check_eq("out_valid", int'(out_valid), int'(v));
    check_eq("signal_out", int'(signal_out), exp_out);
    check_eq("gate_open", int'(gate_open), int'(m_mode != M_CLOSED));
  endtask

  task automatic run_until(input int x, input int mode, input int bound);
    int n = 0;
    while (m_mode != mode && n < bound) begin
      cyc(1'b1, x);
      n++;
    end
    check_eq("reach_bound", int'(n < bound), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signal_in = '0;
    thresh_open = 16'd2000; thresh_close = 16'd1000;
    model_reset();
    repeat (3) @(negedge clk);
    phase = "reset";
    check_eq("out_valid", int'(out_valid), 0);
    check_eq("signal_out", int'(signal_out), 0);
    check_eq("gate_open", int'(gate_open), 0);
    rst_n = 1'b1;
    @(negedge clk);

    phase = "quiet";
    cyc(1'b1, 1000);
    check_eq("muted", int'(signal_out), 0);
    cyc(1'b0, 0);

    phase = "attack";
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8000);
      if (i == 0) check_eq("first_out", int'(signal_out), 500);
    end
    check_eq("unity_out", int'(signal_out), 8000);
    check_eq("opened", int'(gate_open), 1);

    phase = "decay";
    run_until(500, M_CLOSED, 3000);
    check_eq("closed_out", int'(signal_out), 0);

    phase = "reattack";
    run_until(8000, M_OPEN, 100);
    begin
      int n = 0;
      while (!(m_mode == M_RELEASE && m_gain == 128) && n < 3000) begin
        cyc(1'b1, 500);
        n++;
      end
      check_eq("release_bound", int'(n < 3000), 1);
    end
    cyc(1'b1, 8000);
    check_eq("reattack_out", int'(signal_out), 4500);

    phase = "unity";
    run_until(8000, M_OPEN, 100);
    cyc(1'b1, -32768);
    check_eq("min_pass", int'(signal_out), -32768);
    run_until(0, M_CLOSED, 3000);
    thresh_open = 16'd32767;
    cyc(1'b1, -32768);
    check_eq("sat_open", int'(gate_open), 1);
    thresh_open = 16'd2000;

    phase = "gaps";
    run_until(8000, M_OPEN, 100);
    begin
      int n = 0;
      while (m_mode != M_CLOSED && n < 3000) begin
        cyc(1'b1, 500);
        repeat (3) cyc(1'b0, int'($urandom_range(0, 65535)) - 32768);
        n++;
      end
      check_eq("gap_bound", int'(n < 3000), 1);
    end

    phase = "midreset";
    repeat (5) cyc(1'b1, 8000);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out", int'(signal_out), 0);
    check_eq("rst_gate", int'(gate_open), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8000);
    check_eq("cold_first", int'(signal_out), 500);

    phase = "random";
    begin
      bit loud = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        int amp, x;
        if (i % 250 == 0) begin
          thresh_open  = 16'($urandom_range(0, 20000));
          thresh_close = 16'($urandom_range(0, 20000));
        end
        if ($urandom_range(0, 99) < 2) loud = !loud;
        amp = loud ? 32768 : 800;
        x = int'($urandom_range(0, 2 * amp)) - amp;
        if (x > 32767) x = 32767;
        cyc($urandom_range(0, 3) != 0, x);
      end
    end

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
